// File: rtl/tdm_demux_pkg.sv
// ============================================================================
// Module : tdm_demux_pkg
// Brief  : Shared constants, slot-index type and FSM state encoding for the
//          1x8 TDM demultiplexer.
// Config : TDM_DEMUX_PARITY_EN adds a ninth (even-parity) slot per frame.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tdm_demux_pkg;

  // Data slots carried per frame; this revision is fixed at 8.
  localparam int SLOTS = 8;

  // Width of the one-hot decoder select.
  localparam int SEL_W = $clog2(SLOTS);

`ifdef TDM_DEMUX_PARITY_EN
  // Eight data slots followed by one even-parity slot.
  localparam int FRAME_LEN = SLOTS + 1;
  localparam int SLOT_W    = 4;
`else
  localparam int FRAME_LEN = SLOTS;
  localparam int SLOT_W    = 3;
`endif

  typedef logic [SLOT_W-1:0] slot_t;

  // Index of the final beat of a frame (data slot 7 or parity slot 8).
  localparam slot_t LAST_SLOT = slot_t'(FRAME_LEN - 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Parity bit that makes the total count of ones over data+parity even.
  function automatic logic even_parity_bit(input logic [SLOTS-1:0] data);
    return ^data;
  endfunction

endpackage

`default_nettype wire

// File: rtl/demux1x8_dec.sv
// ============================================================================
// Module : demux1x8_dec
// Brief  : Combinational 3-bit select + enable to 8-bit one-hot write enable.
//          Drives the per-slot shadow register write strobes.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux1x8_dec
  import tdm_demux_pkg::*;
(
  input  logic [SEL_W-1:0] sel_i,
  input  logic             en_i,
  output logic [SLOTS-1:0] wen_o
);

  // One strobe per slot; at most one bit set, none when disabled.
  for (genvar i = 0; i < SLOTS; i++) begin : g_onehot
    assign wen_o[i] = en_i && (sel_i == SEL_W'(i));
  end

endmodule

`default_nettype wire

// File: rtl/tdm_demux_1x8.sv
// ============================================================================
// Module : tdm_demux_1x8
// Brief  : TDM receive demultiplexer. Collects a serial slot stream, framed
//          by a slot-0 sync marker, into a registered 8-bit word. A HUNT /
//          LOCKED FSM tracks alignment and pulses sync_err on misplaced or
//          missing sync.
// Config : TDM_DEMUX_PARITY_EN - 9-slot frames with an even-parity slot,
//          4-bit slot output and an extra parity_err pulse output.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdm_demux_1x8 #(
  parameter int SLOTS = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            din,
  input  logic                            din_valid,
  input  logic                            sync,
  output logic [SLOTS-1:0]                dout,
  output logic                            frame_valid,
  output logic                            locked,
  output logic                            sync_err,
`ifdef TDM_DEMUX_PARITY_EN
  output logic                            parity_err,
`endif
  output logic [tdm_demux_pkg::SLOT_W-1:0] slot
);

  import tdm_demux_pkg::*;

  state_e           state_q, state_d;
  slot_t            slot_q, slot_d;
  logic [SLOTS-1:0] shadow_q, shadow_d;
  logic [SLOTS-1:0] dout_q, dout_d;
  logic             frame_valid_q, frame_valid_d;
  logic             sync_err_q, sync_err_d;
`ifdef TDM_DEMUX_PARITY_EN
  logic             parity_err_q, parity_err_d;
`endif

  logic [SEL_W-1:0] dec_sel;
  logic             dec_en;
  logic [SLOTS-1:0] wen;
  logic             data_slot;

  // The parity slot is consumed by the checker, never stored in the shadow.
`ifdef TDM_DEMUX_PARITY_EN
  assign data_slot = (slot_q != LAST_SLOT);
`else
  assign data_slot = 1'b1;
`endif

  // Shadow write control: a sync beat always lands in slot 0 (frame start in
  // either state, or early-sync restart); other beats only while LOCKED and
  // mid-frame. A sync-less beat at slot 0 is a missing sync and is dropped.
  always_comb begin
    dec_sel = slot_q[SEL_W-1:0];
    dec_en  = 1'b0;
    if (din_valid) begin
      if (sync) begin
        dec_sel = '0;
        dec_en  = 1'b1;
      end else if ((state_q == LOCKED) && (slot_q != '0) && data_slot) begin
        dec_en  = 1'b1;
      end
    end
  end

  demux1x8_dec u_dec (
    .sel_i (dec_sel),
    .en_i  (dec_en),
    .wen_o (wen)
  );

  // Shadow with this cycle's write merged in; on the last data slot this is
  // exactly the completed frame, so dout can load it in the same edge.
  assign shadow_d = (shadow_q & ~wen) | ({SLOTS{din}} & wen);

  // Alignment FSM, slot counter and output pulse generation.
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    dout_d        = dout_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    parity_err_d  = 1'b0;
`endif
    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (sync) begin
            slot_d  = slot_t'(1);
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (sync) begin
            // Normal start when slot is 0; otherwise the partial frame is
            // abandoned and this beat restarts the frame.
            slot_d     = slot_t'(1);
            sync_err_d = (slot_q != '0);
          end else if (slot_q == '0) begin
            sync_err_d = 1'b1;
            state_d    = HUNT;
          end else if (slot_q == LAST_SLOT) begin
            slot_d = '0;
`ifdef TDM_DEMUX_PARITY_EN
            if (din == even_parity_bit(shadow_q)) begin
              dout_d        = shadow_q;
              frame_valid_d = 1'b1;
            end else begin
              parity_err_d  = 1'b1;
            end
`else
            dout_d        = shadow_d;
            frame_valid_d = 1'b1;
`endif
          end else begin
            slot_d = slot_q + slot_t'(1);
          end
        end
        default: begin
          state_d = HUNT;
          slot_d  = '0;
        end
      endcase
    end
  end

  // FSM state and slot counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  // Per-slot shadow storage for the frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  // Registered parallel word and single-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q        <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      parity_err_q  <= 1'b0;
`endif
    end else begin
      dout_q        <= dout_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
`ifdef TDM_DEMUX_PARITY_EN
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign dout        = dout_q;
  assign frame_valid = frame_valid_q;
  assign locked      = (state_q == LOCKED);
  assign sync_err    = sync_err_q;
  assign slot        = slot_q;
`ifdef TDM_DEMUX_PARITY_EN
  assign parity_err  = parity_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux_1x8.sv
// ============================================================================
// Module : tb_tdm_demux_1x8
// Brief  : Self-checking bench for tdm_demux_1x8 with a frame scoreboard.
// Config : honours TDM_DEMUX_PARITY_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tdm_demux_1x8;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int FL = 9;
  localparam int SW = 4;
`else
  localparam int FL = 8;
  localparam int SW = 3;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          din = 1'b0;
  logic          din_valid = 1'b0;
  logic          sync = 1'b0;
  logic [7:0]    dout;
  logic          frame_valid;
  logic          locked;
  logic          sync_err;
  logic [SW-1:0] slot;
`ifdef TDM_DEMUX_PARITY_EN
  logic          parity_err;
`endif

  always #5 clk = ~clk;

  tdm_demux_1x8 #(.SLOTS(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .sync        (sync),
    .dout        (dout),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err),
`ifdef TDM_DEMUX_PARITY_EN
    .parity_err  (parity_err),
`endif
    .slot        (slot)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         serr_cnt = 0;
  int         perr_cnt = 0;
  int         overlap_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         fv_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: captures completed frames and pulse events.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_valid) begin
        obs_q.push_back(dout);
        fv_cyc.push_back(cyc);
      end
      if (sync_err) serr_cnt <= serr_cnt + 1;
      if (sync_err && frame_valid) overlap_cnt <= overlap_cnt + 1;
`ifdef TDM_DEMUX_PARITY_EN
      if (parity_err) perr_cnt <= perr_cnt + 1;
`endif
    end
  end

  task automatic beat(input logic d, input logic s);
    @(negedge clk);
    din = d; sync = s; din_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din = 1'b0; sync = 1'b0; din_valid = 1'b0;
    end
  endtask

  // Drives one full frame back-to-back; bad_par corrupts the parity slot.
  task automatic send_frame(input logic [7:0] data, input logic bad_par);
    logic [7:0] d;
    d = data;
    if (!bad_par) exp_q.push_back(data);
    for (int i = 0; i < FL; i++) begin
      if (i < 8) beat(d[i], i == 0);
      else       beat((^d) ^ bad_par, 1'b0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    #1;
    n_cmp++; if (dout !== 8'h00)     begin n_bad++; $display("FAIL reset_dout got %h want 00", dout); end
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL reset_fv got %b want 0", frame_valid); end
    n_cmp++; if (locked !== 1'b0)    begin n_bad++; $display("FAIL reset_locked got %b want 0", locked); end
    n_cmp++; if (sync_err !== 1'b0)  begin n_bad++; $display("FAIL reset_serr got %b want 0", sync_err); end
    n_cmp++; if (slot !== '0)        begin n_bad++; $display("FAIL reset_slot got %0d want 0", slot); end
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    logic [7:0] e;
    logic [7:0] o;
    logic [7:0] bits;
    bits = 8'b0100_1101;   // slots 0..7 = 1,0,1,1,0,0,1,0
    exp_q.push_back(8'h4D);
    for (int i = 0; i < FL; i++) begin
      if (i < 8) beat(bits[i], i == 0);
      else       beat(^bits, 1'b0);
    end
    idle(2); #1;
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL basic_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL basic_dout got %h want %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL basic_locked got %b want 1", locked); end
    n_cmp++; if (slot !== '0)     begin n_bad++; $display("FAIL basic_slot got %0d want 0", slot); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    logic [7:0] o;
    fv_cyc.delete();
    send_frame(8'hA5, 1'b0);
    send_frame(8'h3C, 1'b0);
    send_frame(8'hFF, 1'b0);
    idle(2); #1;
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL b2b_dout got %h want %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
    n_cmp++;
    if (fv_cyc.size() != 3) begin
      n_bad++; $display("FAIL b2b_pulses got %0d want 3", fv_cyc.size());
    end else if ((fv_cyc[1] - fv_cyc[0] != FL) || (fv_cyc[2] - fv_cyc[1] != FL)) begin
      n_bad++; $display("FAIL b2b_spacing got %0d,%0d want %0d", fv_cyc[1] - fv_cyc[0], fv_cyc[2] - fv_cyc[1], FL);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] bits;
    logic [7:0] e;
    logic [7:0] o;
    bits = 8'h81;
    exp_q.push_back(8'h81);
    for (int i = 0; i < FL; i++) begin
      if (i < 8) beat(bits[i], i == 0);
      else       beat(^bits, 1'b0);
      idle(int'($urandom_range(3, 1)));
      #1;
      if (i < FL - 1) begin
        n_cmp++; if (dout !== 8'hFF) begin n_bad++; $display("FAIL gaps_hold slot %0d got %h want ff", i, dout); end
      end
    end
    idle(1); #1;
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL gaps_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL gaps_dout got %h want %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_early_sync();
    int s0;
    logic [7:0] e;
    logic [7:0] o;
    s0 = serr_cnt;
    beat(1'b1, 1'b1); beat(1'b1, 1'b0); beat(1'b0, 1'b0); beat(1'b1, 1'b0);
    send_frame(8'h5A, 1'b0);   // its sync lands on slot 4 of the partial frame
    idle(2); #1;
    n_cmp++; if (serr_cnt - s0 != 1) begin n_bad++; $display("FAIL early_serr got %0d want 1", serr_cnt - s0); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL early_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL early_dout got %h want %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL early_locked got %b want 1", locked); end
  endtask

  task automatic test_missing_sync();
    int s0;
    logic [7:0] e;
    logic [7:0] o;
    send_frame(8'h96, 1'b0);
    s0 = serr_cnt;
    beat(1'b1, 1'b0); beat(1'b0, 1'b0); beat(1'b1, 1'b0); beat(1'b1, 1'b0);
    idle(2); #1;
    n_cmp++; if (serr_cnt - s0 != 1) begin n_bad++; $display("FAIL miss_serr got %0d want 1", serr_cnt - s0); end
    n_cmp++; if (locked !== 1'b0)    begin n_bad++; $display("FAIL miss_locked got %b want 0", locked); end
    n_cmp++; if (dout !== 8'h96)     begin n_bad++; $display("FAIL miss_dout_hold got %h want 96", dout); end
    n_cmp++; if (slot !== '0)        begin n_bad++; $display("FAIL miss_slot got %0d want 0", slot); end
    send_frame(8'h3C, 1'b0);
    idle(2); #1;
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL miss_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL miss_dout got %h want %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_async_reset();
    int s0;
    logic [7:0] e;
    logic [7:0] o;
    logic [7:0] bits;
    bits = 8'h6B;
    for (int i = 0; i < 6; i++) beat(bits[i], i == 0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (dout !== 8'h00)       begin n_bad++; $display("FAIL arst_dout got %h want 00", dout); end
    n_cmp++; if (locked !== 1'b0)      begin n_bad++; $display("FAIL arst_locked got %b want 0", locked); end
    n_cmp++; if (slot !== '0)          begin n_bad++; $display("FAIL arst_slot got %0d want 0", slot); end
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL arst_fv got %b want 0", frame_valid); end
    @(negedge clk);
    din_valid = 1'b0; sync = 1'b0;
    rst_n = 1'b1;
    s0 = serr_cnt;
    for (int i = 6; i < 8; i++) beat(bits[i], 1'b0);
    for (int i = 0; i < FL; i++) beat(i[0], 1'b0);
    idle(2); #1;
    n_cmp++; if (obs_q.size() != 0)   begin n_bad++; $display("FAIL arst_nosync_frames got %0d want 0", obs_q.size()); end
    n_cmp++; if (serr_cnt != s0)      begin n_bad++; $display("FAIL arst_hunt_serr got %0d want 0", serr_cnt - s0); end
    obs_q.delete();
    send_frame(8'hC3, 1'b0);
    idle(2); #1;
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL arst_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL arst_dout got %h want %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

`ifdef TDM_DEMUX_PARITY_EN
  task automatic test_parity();
    int p0;
    logic [7:0] e;
    logic [7:0] o;
    send_frame(8'h5A, 1'b0);
    p0 = perr_cnt;
    send_frame(8'h07, 1'b1);   // correct parity bit is 1, 0 is sent
    idle(2); #1;
    n_cmp++; if (perr_cnt - p0 != 1) begin n_bad++; $display("FAIL par_err got %0d want 1", perr_cnt - p0); end
    n_cmp++; if (dout !== 8'h5A)     begin n_bad++; $display("FAIL par_hold got %h want 5a", dout); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL par_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL par_dout got %h want %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_gaps();
    test_early_sync();
    test_missing_sync();
    test_async_reset();
`ifdef TDM_DEMUX_PARITY_EN
    test_parity();
`endif
    n_cmp++; if (overlap_cnt != 0) begin n_bad++; $display("FAIL pulse_overlap got %0d want 0", overlap_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/tdm_demux_1x8.md
# tdm_demux_1x8

Time-division demultiplexer that undoes the 8:1 select multiplexing performed upstream: it receives a 1-bit serial slot stream with a frame-sync marker and distributes the eight slots into a registered 8-bit parallel word. It is the receive end of the mux datapath and feeds downstream logic one complete frame per `frame_valid` pulse. A small hunt/locked FSM tracks frame alignment and flags sync errors.

## Interface
Parameters:
- `SLOTS`, 8: data slots per frame; fixed at 8 in this revision.

Ports:
- `clk`  input  1  single clock; all logic on rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `din`  input  1  serial slot data
- `din_valid`  input  1  `din` carries a slot this cycle
- `sync`  input  1  qualified by `din_valid`; marks slot 0 of a frame
- `dout`  output  8  last complete frame; bit i = slot i
- `frame_valid`  output  1  one-cycle pulse: `dout` updated this cycle
- `locked`  output  1  FSM in LOCKED
- `sync_err`  output  1  one-cycle pulse: misplaced or missing sync
- `slot`  output  3  index of next expected slot

## Operation
- Reset values: `dout`=8'h00, `frame_valid`=0, `locked`=0, `sync_err`=0, `slot`=0, FSM=HUNT, shadow register cleared.
- Accepted beat: `din_valid`=1. No beat: all state holds, pulses deassert.
- HUNT: beats without `sync` discarded. Beat with `sync`: `din` written to shadow[0], `slot`<=1, go LOCKED.
- LOCKED, beat, `sync`=0, `slot`!=0: write shadow[`slot`], `slot`++.
- LOCKED, beat, `sync`=1, `slot`==0: normal frame start, write shadow[0], `slot`<=1.
- LOCKED, beat, `sync`=1, `slot`!=0: early sync. Partial frame discarded, `sync_err` pulse, beat taken as new slot 0, `slot`<=1, stay LOCKED.
- LOCKED, beat, `sync`=0, `slot`==0: missing sync. `sync_err` pulse, beat discarded, go HUNT, `locked`<=0.
- Last slot (`slot`==7, accepted beat): `dout`<= {din, shadow[6:0]}, `frame_valid` pulse, `slot` wraps to 0.
- Slot write enables: one-hot decode of `slot`, gated by accepted beat and LOCKED (or sync in HUNT).
- `dout` holds between frames; never partially updated.

## Timing
- Latency: `dout`/`frame_valid` registered; valid the cycle after the 8th beat is sampled.
- Back-to-back frames: sustains 1 slot/cycle; `frame_valid` at most every 8 accepted beats.
- Gaps (`din_valid`=0) anywhere in a frame allowed; no timeout.
- `sync_err` and `frame_valid` never assert together.
- Reset mid-frame: asynchronous clear to reset values; partial frame lost; next frame requires `sync`.

## Configuration
- `TDM_DEMUX_PARITY_EN` defined: frame is 9 slots; slot 8 is even parity over slots 0-7. `slot` output widens to 4 bits; adds output `parity_err` (1-bit pulse). On slot-8 beat: parity match -> `dout` update + `frame_valid`; mismatch -> `dout` held, `parity_err` pulse, no `frame_valid`. Early/missing-sync rules apply with `slot`!=0 / ==0 over 0-8.
- Undefined: 8-slot frames, no parity slot, no `parity_err` port.

## Structure
- Package `tdm_demux_pkg`: `SLOTS`, frame-length constant (8 or 9 per macro), slot-index width, FSM state enum (`HUNT`, `LOCKED`).
- Sub-module `demux1x8_dec`: combinational 3-bit select + enable -> 8-bit one-hot write enable; the top owns FSM, counter, shadow and output registers.

## Test plan
- Reset then frame slots 0..7 = 1,0,1,1,0,0,1,0 with `sync` on slot 0 -> `dout`=8'h4D, one `frame_valid` pulse, `locked`=1.
- Three back-to-back frames 8'hA5, 8'h3C, 8'hFF, no gaps -> `frame_valid` every 8 cycles, `dout` in order.
- Frame with `din_valid` gaps of 1-3 cycles between slots, data 8'h81 -> same result, `dout` unchanged until last slot.
- `sync` on slot 4 of a frame -> `sync_err` pulse, no `frame_valid`, next 8 beats from that sync yield their frame.
- Frame completes, next beat lacks `sync` -> `sync_err`, `locked`=0, following beats ignored until `sync`; `dout` keeps last frame.
- `rst_n` low at slot 5 -> all outputs zero immediately; with `TDM_DEMUX_PARITY_EN`, frame 8'h07 parity 0 -> `parity_err`, `dout` unchanged.
